issueq_wakeup_ready: RTL and testbench
======================================

Name: issueq_wakeup_ready

Overview:
- Per-entry ready-tracking state for the 32-entry issue queue, directly upstream of the issue select tree.
- Records source-operand tags and ready bits when instructions dispatch.
- Matches result-tag broadcasts (wakeup) against waiting operands.
- Drives the request vector consumed by select; retires the granted entry from the following cycle.

Parameters:
- SIZE_ISSUEQ, 32, number of issue queue entries.
- SIZE_ISSUEQ_LOG, 5, log2(SIZE_ISSUEQ); width of entry indices.
- SIZE_PHYSICAL_LOG, 7, physical register tag width.
- WAKEUP_WIDTH, 2, number of tag broadcast ports per cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  squash; invalidates every entry.
- dispatchValid_i  in  1  write one new entry this cycle.
- dispatchEntry_i  in  SIZE_ISSUEQ_LOG  entry index to write; must currently be free.
- dispatchSrc1Tag_i  in  SIZE_PHYSICAL_LOG  source-1 physical tag.
- dispatchSrc1Ready_i  in  1  source-1 already available.
- dispatchSrc2Tag_i  in  SIZE_PHYSICAL_LOG  source-2 physical tag.
- dispatchSrc2Ready_i  in  1  source-2 already available.
- wakeupValid_i  in  WAKEUP_WIDTH  per-port broadcast valid.
- wakeupTags_i  in  WAKEUP_WIDTH*SIZE_PHYSICAL_LOG  broadcast tags; port k occupies bits [k*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG].
- grantedValid_i  in  1  select granted an entry this cycle.
- grantedEntry_i  in  SIZE_ISSUEQ_LOG  encoded granted entry index.
- requestVector_o  out  SIZE_ISSUEQ  bit i = valid[i] & rdy1[i] & rdy2[i].
- entryValid_o  out  SIZE_ISSUEQ  occupancy bitmap for the free-entry allocator.

Behaviour:
- Per-entry state: valid, tag1, rdy1, tag2, rdy2, all flops.
  - Outputs are decoded combinationally from the flops only; no input-to-output combinational path.
- Reset (reset==0, asynchronous): all valid, rdy1 and rdy2 cleared; tags cleared to 0.
  - requestVector_o = 0 and entryValid_o = 0 while reset is held and after release.
- Dispatch: on dispatchValid_i, the entry at dispatchEntry_i takes valid=1 and the tags and ready bits as given, at the next edge.
  - Dispatch-time bypass: rdyN is also set if dispatchSrcNTag_i equals any valid wakeup tag in the same cycle.
  - Latency: dispatch in cycle N with both sources ready gives the request bit high in cycle N+1.
- Wakeup: for every valid entry, rdyN is set at the next edge if tagN equals wakeupTags_i on any port with wakeupValid_i set.
  - Ready bits are sticky; they never clear while the entry is valid.
  - Invalid entries ignore wakeup.
  - Duplicate tags across ports are harmless.
- Grant: grantedValid_i in cycle N clears valid of grantedEntry_i at the edge ending cycle N.
  - The request bit is therefore low in N+1, so select cannot re-grant the entry.
  - Granting an entry whose request bit is low is a protocol violation; the design must still clear valid.
- Priority per entry (highest first): reset, flush_i, grant, dispatch, wakeup.
  - Flush in the same cycle as dispatch: the dispatch is dropped.
  - Grant and dispatch to the same index in the same cycle is a protocol violation. Dispatch must not target a valid entry. Both are flagged by simulation assertions; in that case grant wins.
- A reset asserted mid-operation discards all entries immediately (asynchronous), with no partial state retained.
- No handshake or backpressure on this block. Upstream guarantees a free entry; select guarantees at most one grant per cycle.

Optional Feature:
- ISSUEQ_OCCUPANCY_COUNT_EN defined adds output issueqCount_o [SIZE_ISSUEQ_LOG:0]: a registered count of valid entries.
  - Each cycle: +1 on an accepted dispatch, −1 on a grant of a valid entry. Reset and flush set it to 0.
  - It must always equal popcount(entryValid_o).
- Without the macro, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: SIZE_ISSUEQ, SIZE_ISSUEQ_LOG, SIZE_PHYSICAL_LOG, WAKEUP_WIDTH defaults; a typedef for the entry record (valid, tag1, rdy1, tag2, rdy2).
- Sub-module issueq_tag_match: compares one tag against all WAKEUP_WIDTH ports and returns the match bit.
  - Instantiated 2*SIZE_ISSUEQ times for entries, plus 2 for the dispatch bypass.

Test Plan:
- Reset held, then released; dispatch entry 3 with both sources ready -> requestVector_o == 32'h0000_0008 one cycle later; entryValid_o bit 3 set.
- Dispatch entry 5 with tag1=0x11 not ready and src2 ready; broadcast tag 0x11 on port 1 two cycles later -> bit 5 of requestVector_o rises exactly one cycle after the broadcast.
- Dispatch entry 7 with tag2=0x22 not ready while 0x22 is broadcast on port 0 in the same cycle -> bit 7 high next cycle (bypass).
- Entries 0 and 9 requesting; grant entry 0 -> requestVector_o == 32'h0000_0200 next cycle; entry 0 is not re-requested.
- Eight entries valid; assert flush_i together with a dispatch to entry 20 -> requestVector_o == 0 and entryValid_o == 0 next cycle; with ISSUEQ_OCCUPANCY_COUNT_EN, issueqCount_o == 0.
- Fill all 32 entries, then grant one per cycle, with ISSUEQ_OCCUPANCY_COUNT_EN -> count goes 32 down to 0 with no underflow; an async reset pulse mid-sequence clears everything within the same cycle.

Source files
------------

// File: rtl/issueq_wakeup_ready_pkg.sv
// Shared sizing constants and the per-entry ready-tracking record for the
// issue-queue wakeup/ready block.
package issueq_wakeup_ready_pkg;

  localparam int SIZE_ISSUEQ       = 32;
  localparam int SIZE_ISSUEQ_LOG   = 5;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int WAKEUP_WIDTH      = 2;

  typedef logic [SIZE_PHYSICAL_LOG-1:0] tag_t;

  typedef struct packed {
    logic valid;
    tag_t tag1;
    logic rdy1;
    tag_t tag2;
    logic rdy2;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{
    valid: 1'b0,
    tag1:  {SIZE_PHYSICAL_LOG{1'b0}},
    rdy1:  1'b0,
    tag2:  {SIZE_PHYSICAL_LOG{1'b0}},
    rdy2:  1'b0
  };

  // An entry asks select for issue only when it holds an instruction whose
  // two source operands are both available.
  function automatic logic entry_requests(input entry_t e);
    return e.valid & e.rdy1 & e.rdy2;
  endfunction

endpackage

// File: rtl/issueq_wakeup_ready_checker.sv
// Protocol checker for issueq_wakeup_ready: flags dispatch/grant collisions,
// dispatch into an occupied entry and (with ISSUEQ_OCCUPANCY_COUNT_EN) any
// drift between the occupancy counter and the valid bitmap.
module issueq_wakeup_ready_checker
  import issueq_wakeup_ready_pkg::*;
(
  input logic                       clk,
  input logic                       reset,
  input logic                       dispatch_valid,
  input logic [SIZE_ISSUEQ_LOG-1:0] dispatch_entry,
  input logic                       granted_valid,
  input logic [SIZE_ISSUEQ_LOG-1:0] granted_entry,
  input logic [SIZE_ISSUEQ-1:0]     entry_valid
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
  ,
  input logic [SIZE_ISSUEQ_LOG:0]   count
`endif
);

  a_no_grant_dispatch_same_entry : assert property (@(posedge clk) disable iff (!reset)
    !(dispatch_valid && granted_valid && (dispatch_entry == granted_entry)));

  a_dispatch_to_free_entry : assert property (@(posedge clk) disable iff (!reset)
    !(dispatch_valid && entry_valid[dispatch_entry]));

`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
  a_count_matches_popcount : assert property (@(posedge clk) disable iff (!reset)
    (32'(count) == $countones(entry_valid)));
`endif

endmodule

// File: rtl/issueq_wakeup_ready_tag_match.sv
// issueq_tag_match: compares one physical tag against every wakeup broadcast
// port and reports whether any valid port carries that tag.
module issueq_tag_match
  import issueq_wakeup_ready_pkg::*;
#(
  parameter int TAG_W = SIZE_PHYSICAL_LOG,
  parameter int PORTS = WAKEUP_WIDTH
) (
  input  logic [TAG_W-1:0]       tag,
  input  logic [PORTS-1:0]       wakeup_valid,
  input  logic [PORTS*TAG_W-1:0] wakeup_tags,
  output logic                   match
);

  // OR together the per-port equality results; duplicate tags are harmless.
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      match = match | (wakeup_valid[k] & (wakeup_tags[k*TAG_W +: TAG_W] == tag));
    end
  end

endmodule

// File: rtl/issueq_wakeup_ready.sv
// issueq_wakeup_ready: per-entry operand ready tracking for a 32-entry issue
// queue. Captures tags/ready bits at dispatch, applies tag wakeups, retires
// granted entries and drives the request vector for the select tree.
// Optional feature macro: ISSUEQ_OCCUPANCY_COUNT_EN adds issueqCount_o, a
// registered count of valid entries.
module issueq_wakeup_ready
  import issueq_wakeup_ready_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush_i,
  input  logic                                      dispatchValid_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0]                dispatchEntry_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]              dispatchSrc1Tag_i,
  input  logic                                      dispatchSrc1Ready_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]              dispatchSrc2Tag_i,
  input  logic                                      dispatchSrc2Ready_i,
  input  logic [WAKEUP_WIDTH-1:0]                   wakeupValid_i,
  input  logic [WAKEUP_WIDTH*SIZE_PHYSICAL_LOG-1:0] wakeupTags_i,
  input  logic                                      grantedValid_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0]                grantedEntry_i,
  output logic [SIZE_ISSUEQ-1:0]                    requestVector_o,
  output logic [SIZE_ISSUEQ-1:0]                    entryValid_o
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
  ,
  output logic [SIZE_ISSUEQ_LOG:0]                  issueqCount_o
`endif
);

  entry_t entries_r      [SIZE_ISSUEQ];
  entry_t entries_next_s [SIZE_ISSUEQ];

  logic [SIZE_ISSUEQ-1:0] match1_s;
  logic [SIZE_ISSUEQ-1:0] match2_s;
  logic                   disp_match1_s;
  logic                   disp_match2_s;

  // Wakeup comparators for the two stored tags of every entry.
  for (genvar i = 0; i < SIZE_ISSUEQ; i++) begin : g_entry_match
    issueq_tag_match #(.TAG_W(SIZE_PHYSICAL_LOG), .PORTS(WAKEUP_WIDTH)) u_match1 (
      .tag          (entries_r[i].tag1),
      .wakeup_valid (wakeupValid_i),
      .wakeup_tags  (wakeupTags_i),
      .match        (match1_s[i])
    );
    issueq_tag_match #(.TAG_W(SIZE_PHYSICAL_LOG), .PORTS(WAKEUP_WIDTH)) u_match2 (
      .tag          (entries_r[i].tag2),
      .wakeup_valid (wakeupValid_i),
      .wakeup_tags  (wakeupTags_i),
      .match        (match2_s[i])
    );
  end

  // Dispatch-time bypass: a source produced in the dispatch cycle is ready.
  issueq_tag_match #(.TAG_W(SIZE_PHYSICAL_LOG), .PORTS(WAKEUP_WIDTH)) u_disp_match1 (
    .tag          (dispatchSrc1Tag_i),
    .wakeup_valid (wakeupValid_i),
    .wakeup_tags  (wakeupTags_i),
    .match        (disp_match1_s)
  );
  issueq_tag_match #(.TAG_W(SIZE_PHYSICAL_LOG), .PORTS(WAKEUP_WIDTH)) u_disp_match2 (
    .tag          (dispatchSrc2Tag_i),
    .wakeup_valid (wakeupValid_i),
    .wakeup_tags  (wakeupTags_i),
    .match        (disp_match2_s)
  );

  // Next entry state with priority flush > grant > dispatch > wakeup.
  always_comb begin
    for (int i = 0; i < SIZE_ISSUEQ; i++) begin
      entries_next_s[i] = entries_r[i];
      if (flush_i) begin
        entries_next_s[i].valid = 1'b0;
      end else if (grantedValid_i && (grantedEntry_i == SIZE_ISSUEQ_LOG'(i))) begin
        entries_next_s[i].valid = 1'b0;
      end else if (dispatchValid_i && (dispatchEntry_i == SIZE_ISSUEQ_LOG'(i))) begin
        entries_next_s[i].valid = 1'b1;
        entries_next_s[i].tag1  = dispatchSrc1Tag_i;
        entries_next_s[i].rdy1  = dispatchSrc1Ready_i | disp_match1_s;
        entries_next_s[i].tag2  = dispatchSrc2Tag_i;
        entries_next_s[i].rdy2  = dispatchSrc2Ready_i | disp_match2_s;
      end else if (entries_r[i].valid) begin
        entries_next_s[i].rdy1 = entries_r[i].rdy1 | match1_s[i];
        entries_next_s[i].rdy2 = entries_r[i].rdy2 | match2_s[i];
      end else begin
        entries_next_s[i] = entries_r[i];
      end
    end
  end

  // Entry state flops; reset discards every entry immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE_ISSUEQ; i++) begin
        entries_r[i] <= ENTRY_RESET;
      end
    end else begin
      for (int i = 0; i < SIZE_ISSUEQ; i++) begin
        entries_r[i] <= entries_next_s[i];
      end
    end
  end

  // Request and occupancy vectors decoded purely from the entry flops.
  always_comb begin
    requestVector_o = {SIZE_ISSUEQ{1'b0}};
    entryValid_o    = {SIZE_ISSUEQ{1'b0}};
    for (int i = 0; i < SIZE_ISSUEQ; i++) begin
      requestVector_o[i] = entry_requests(entries_r[i]);
      entryValid_o[i]    = entries_r[i].valid;
    end
  end

`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
  logic [SIZE_ISSUEQ_LOG:0] count_r;
  logic                     count_inc_s;
  logic                     count_dec_s;

  // A dispatch only adds an entry when it lands on a free slot and is not
  // overridden by a grant to the same index; only valid grants remove one.
  always_comb begin
    count_dec_s = grantedValid_i & entries_r[grantedEntry_i].valid;
    count_inc_s = dispatchValid_i & ~entries_r[dispatchEntry_i].valid &
                  ~(grantedValid_i & (grantedEntry_i == dispatchEntry_i));
  end

  // Occupancy counter; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {(SIZE_ISSUEQ_LOG+1){1'b0}};
    end else if (flush_i) begin
      count_r <= {(SIZE_ISSUEQ_LOG+1){1'b0}};
    end else begin
      count_r <= count_r + {{SIZE_ISSUEQ_LOG{1'b0}}, count_inc_s}
                         - {{SIZE_ISSUEQ_LOG{1'b0}}, count_dec_s};
    end
  end

  assign issueqCount_o = count_r;
`endif

  issueq_wakeup_ready_checker u_checker (
    .clk            (clk),
    .reset          (reset),
    .dispatch_valid (dispatchValid_i),
    .dispatch_entry (dispatchEntry_i),
    .granted_valid  (grantedValid_i),
    .granted_entry  (grantedEntry_i),
    .entry_valid    (entryValid_o)
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
    ,
    .count          (count_r)
`endif
  );

endmodule

// File: tb/tb_issueq_wakeup_ready.sv
// Self-checking bench for issueq_wakeup_ready: directed per-cycle vector
// table, drain/async-reset sequence and a randomized run against a
// behavioural model. Honours ISSUEQ_OCCUPANCY_COUNT_EN.
module tb_issueq_wakeup_ready;
  import issueq_wakeup_ready_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        dv;
  logic [4:0]  de;
  logic [6:0]  t1, t2;
  logic        r1, r2;
  logic [1:0]  wv;
  logic [6:0]  w0, w1;
  logic        gv;
  logic [4:0]  ge;
  logic [31:0] req, val;
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
  logic [5:0]  cnt;
`endif

  always #5 clk = ~clk;

  issueq_wakeup_ready dut (
    .clk                 (clk),
    .reset               (reset),
    .flush_i             (flush),
    .dispatchValid_i     (dv),
    .dispatchEntry_i     (de),
    .dispatchSrc1Tag_i   (t1),
    .dispatchSrc1Ready_i (r1),
    .dispatchSrc2Tag_i   (t2),
    .dispatchSrc2Ready_i (r2),
    .wakeupValid_i       (wv),
    .wakeupTags_i        ({w1, w0}),
    .grantedValid_i      (gv),
    .grantedEntry_i      (ge),
    .requestVector_o     (req),
    .entryValid_o        (val)
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
    ,
    .issueqCount_o       (cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: one record per slot, updated with the queue rules.
  bit         m_valid [32];
  logic [6:0] m_t1    [32];
  logic [6:0] m_t2    [32];
  bit         m_r1    [32];
  bit         m_r2    [32];

  function automatic logic [31:0] m_req();
    logic [31:0] v = 32'd0;
    for (int i = 0; i < 32; i++) v[i] = m_valid[i] && m_r1[i] && m_r2[i];
    return v;
  endfunction

  function automatic logic [31:0] m_val();
    logic [31:0] v = 32'd0;
    for (int i = 0; i < 32; i++) v[i] = m_valid[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0;
      m_t1[i] = 7'd0; m_t2[i] = 7'd0;
    end
  endtask

  task automatic model_step();
    bit woke [128];
    for (int t = 0; t < 128; t++) woke[t] = 1'b0;
    if (wv[0]) woke[w0] = 1'b1;
    if (wv[1]) woke[w1] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (flush) m_valid[i] = 1'b0;
      else if (gv && ge == i) m_valid[i] = 1'b0;
      else if (dv && de == i) begin
        m_valid[i] = 1'b1;
        m_t1[i] = t1; m_r1[i] = r1 || woke[t1];
        m_t2[i] = t2; m_r2[i] = r2 || woke[t2];
      end else if (m_valid[i]) begin
        if (woke[m_t1[i]]) m_r1[i] = 1'b1;
        if (woke[m_t2[i]]) m_r2[i] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; dv = 1'b0; de = 5'd0; t1 = 7'd0; r1 = 1'b0; t2 = 7'd0; r2 = 1'b0;
    wv = 2'b00; w0 = 7'd0; w1 = 7'd0; gv = 1'b0; ge = 5'd0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string name);
    chk({name, "_req"}, {32'd0, req}, {32'd0, m_req()});
    chk({name, "_valid"}, {32'd0, val}, {32'd0, m_val()});
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
    chk({name, "_count"}, {58'd0, cnt}, 64'($countones(m_val())));
`endif
  endtask

  typedef struct {
    bit          flush, dv;
    logic [4:0]  de;
    logic [6:0]  t1;
    bit          r1;
    logic [6:0]  t2;
    bit          r2;
    logic [1:0]  wv;
    logic [6:0]  w0, w1;
    bit          gv;
    logic [4:0]  ge;
    logic [31:0] exp_req, exp_val;
  } vec_t;

  function automatic vec_t mk(bit f, bit d, logic [4:0] e, logic [6:0] a1, bit b1,
                              logic [6:0] a2, bit b2, logic [1:0] v, logic [6:0] x0,
                              logic [6:0] x1, bit g, logic [4:0] gi,
                              logic [31:0] er, logic [31:0] ev);
    vec_t r;
    r.flush = f; r.dv = d; r.de = e; r.t1 = a1; r.r1 = b1; r.t2 = a2; r.r2 = b2;
    r.wv = v; r.w0 = x0; r.w1 = x1; r.gv = g; r.ge = gi; r.exp_req = er; r.exp_val = ev;
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] acc;
    int          q[$];
    int          pick;

    // Directed table: one record per clock cycle.
    vecs.push_back(mk(0,1, 5'd3, 7'h01,1, 7'h02,1, 2'b00,7'h00,7'h00, 0,5'd0, 32'h0000_0008, 32'h0000_0008));
    vecs.push_back(mk(0,1, 5'd5, 7'h11,0, 7'h12,1, 2'b00,7'h00,7'h00, 0,5'd0, 32'h0000_0008, 32'h0000_0028));
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b00,7'h00,7'h00, 0,5'd0, 32'h0000_0008, 32'h0000_0028));
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b10,7'h00,7'h11, 0,5'd0, 32'h0000_0028, 32'h0000_0028));
    vecs.push_back(mk(0,1, 5'd7, 7'h30,1, 7'h22,0, 2'b01,7'h22,7'h00, 0,5'd0, 32'h0000_00A8, 32'h0000_00A8));
    vecs.push_back(mk(0,1, 5'd0, 7'h01,1, 7'h02,1, 2'b00,7'h00,7'h00, 0,5'd0, 32'h0000_00A9, 32'h0000_00A9));
    vecs.push_back(mk(0,1, 5'd9, 7'h03,1, 7'h04,1, 2'b00,7'h00,7'h00, 0,5'd0, 32'h0000_02A9, 32'h0000_02A9));
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b00,7'h00,7'h00, 1,5'd3, 32'h0000_02A1, 32'h0000_02A1));
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b00,7'h00,7'h00, 1,5'd5, 32'h0000_0281, 32'h0000_0281));
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b00,7'h00,7'h00, 1,5'd7, 32'h0000_0201, 32'h0000_0201));
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b00,7'h00,7'h00, 1,5'd0, 32'h0000_0200, 32'h0000_0200));
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b00,7'h00,7'h00, 0,5'd0, 32'h0000_0200, 32'h0000_0200));
    acc = 32'h0000_0200;
    for (int i = 10; i <= 16; i++) begin
      acc[i] = 1'b1;
      vecs.push_back(mk(0,1, 5'(i), 7'h41,1, 7'h40,0, 2'b00,7'h00,7'h00, 0,5'd0, 32'h0000_0200, acc));
    end
    // Grant of a valid but non-requesting entry still retires it.
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b00,7'h00,7'h00, 1,5'd10, 32'h0000_0200, 32'h0001_FA00));
    // Same tag on both ports, plus a bypassed dispatch: eight entries valid.
    vecs.push_back(mk(0,1, 5'd17, 7'h41,1, 7'h40,0, 2'b11,7'h40,7'h40, 0,5'd0, 32'h0003_FA00, 32'h0003_FA00));
    // Flush drops the simultaneous dispatch.
    vecs.push_back(mk(1,1, 5'd20, 7'h01,1, 7'h02,1, 2'b00,7'h00,7'h00, 0,5'd0, 32'h0000_0000, 32'h0000_0000));
    vecs.push_back(mk(0,1, 5'd1, 7'h05,0, 7'h06,1, 2'b00,7'h00,7'h00, 0,5'd0, 32'h0000_0000, 32'h0000_0002));
    // Matching tag on an invalid port must not wake.
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b00,7'h05,7'h05, 0,5'd0, 32'h0000_0000, 32'h0000_0002));
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b01,7'h05,7'h00, 0,5'd0, 32'h0000_0002, 32'h0000_0002));
    vecs.push_back(mk(0,0, 5'd0, 7'h00,0, 7'h00,0, 2'b00,7'h00,7'h00, 1,5'd1, 32'h0000_0000, 32'h0000_0000));

    // Reset held, then released.
    idle();
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_held_req", {32'd0, req}, 64'd0);
    chk("rst_held_valid", {32'd0, val}, 64'd0);
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
    chk("rst_held_count", {58'd0, cnt}, 64'd0);
`endif
    reset = 1'b1;
    tick();
    chk("rst_rel_req", {32'd0, req}, 64'd0);
    chk("rst_rel_valid", {32'd0, val}, 64'd0);

    // Directed table.
    for (int n = 0; n < vecs.size(); n++) begin
      flush = vecs[n].flush; dv = vecs[n].dv; de = vecs[n].de;
      t1 = vecs[n].t1; r1 = vecs[n].r1; t2 = vecs[n].t2; r2 = vecs[n].r2;
      wv = vecs[n].wv; w0 = vecs[n].w0; w1 = vecs[n].w1;
      gv = vecs[n].gv; ge = vecs[n].ge;
      tick();
      chk($sformatf("vec%0d_req", n), {32'd0, req}, {32'd0, vecs[n].exp_req});
      chk($sformatf("vec%0d_valid", n), {32'd0, val}, {32'd0, vecs[n].exp_val});
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
      chk($sformatf("vec%0d_count", n), {58'd0, cnt}, 64'($countones(vecs[n].exp_val)));
`endif
    end
    idle();

    // Fill all 32 entries, then drain one grant per cycle.
    for (int i = 0; i < 32; i++) begin
      idle(); dv = 1'b1; de = 5'(i); t1 = 7'(i); r1 = 1'b1; t2 = 7'(i + 32); r2 = 1'b1;
      tick();
    end
    idle();
    chk("fill_valid", {32'd0, val}, 64'hFFFF_FFFF);
    chk("fill_req", {32'd0, req}, 64'hFFFF_FFFF);
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
    chk("fill_count", {58'd0, cnt}, 64'd32);
`endif
    for (int i = 0; i < 32; i++) begin
      idle(); gv = 1'b1; ge = 5'(i);
      tick();
      check_model($sformatf("drain%0d", i));
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
      chk($sformatf("drain%0d_count_abs", i), {58'd0, cnt}, 64'(31 - i));
`endif
    end
    // Extra grant on an empty queue: no underflow.
    idle(); gv = 1'b1; ge = 5'd0;
    tick();
    check_model("underflow");

    // Refill, retire a few, then pulse reset away from any clock edge.
    for (int i = 0; i < 16; i++) begin
      idle(); dv = 1'b1; de = 5'(i); t1 = 7'd1; r1 = 1'b1; t2 = 7'd2; r2 = 1'b1;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      idle(); gv = 1'b1; ge = 5'(i);
      tick();
    end
    idle();
    check_model("pre_async");
    #2 reset = 1'b0;
    #1;
    chk("async_req", {32'd0, req}, 64'd0);
    chk("async_valid", {32'd0, val}, 64'd0);
`ifdef ISSUEQ_OCCUPANCY_COUNT_EN
    chk("async_count", {58'd0, cnt}, 64'd0);
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_model("post_async");

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      idle();
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) != 0) begin
        q.delete();
        for (int i = 0; i < 32; i++) if (!m_valid[i]) q.push_back(i);
        if (q.size() > 0) begin
          pick = q[$urandom_range(0, q.size() - 1)];
          dv = 1'b1; de = 5'(pick);
          t1 = 7'($urandom_range(0, 15)); r1 = ($urandom_range(0, 3) == 0);
          t2 = 7'($urandom_range(0, 15)); r2 = ($urandom_range(0, 3) == 0);
        end
      end
      wv = 2'($urandom_range(0, 3));
      w0 = 7'($urandom_range(0, 15));
      w1 = 7'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        q.delete();
        for (int i = 0; i < 32; i++) if (m_valid[i] && m_r1[i] && m_r2[i]) q.push_back(i);
        if (q.size() > 0) begin
          gv = 1'b1; ge = 5'(q[$urandom_range(0, q.size() - 1)]);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        q.delete();
        for (int i = 0; i < 32; i++) if (m_valid[i]) q.push_back(i);
        if (q.size() > 0) begin
          gv = 1'b1; ge = 5'(q[$urandom_range(0, q.size() - 1)]);
        end
      end
      tick();
      check_model($sformatf("rnd%0d", c));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
